// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - call/return sequencer for the hardware return-address stack
//
// Purpose:
//   Accepts CALL / RET / FLUSH requests from decode, drives the return-address
//   stack strobes, produces the new PC with a one-cycle load strobe and keeps
//   sticky overflow / underflow flags. Every output decodes from registers.
//
// Ports:
//   CLK, nRST        clock (rising edge), asynchronous active-low reset
//   CALL, RET, FLUSH requests, sampled in IDLE only (FLUSH > CALL > RET)
//   CLR_ERR          clears ERR_OVF / ERR_UNF (a same-edge new error wins)
//   PC_IN, TARGET    address of the CALL instruction, CALL destination
//   PC_OUT, PC_LOAD  new PC value and its one-cycle load strobe
//   BUSY, DONE       request in progress, one-cycle completion pulse
//   ERR_OVF, ERR_UNF sticky fault flags
//   DEPTH_CNT        number of valid stack entries, 0..2**DEPTH
//   STK_*            stack interface (DATA_IN/CE/nRW out, DATA_OUT/FULL/EMPTY in)

module stack_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 3
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  CALL,
  input  logic                  RET,
  input  logic                  FLUSH,
  input  logic                  CLR_ERR,
  input  logic [ADDR_WIDTH-1:0] PC_IN,
  input  logic [ADDR_WIDTH-1:0] TARGET,
  output logic [ADDR_WIDTH-1:0] PC_OUT,
  output logic                  PC_LOAD,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR_OVF,
  output logic                  ERR_UNF,
  output logic [DEPTH:0]        DEPTH_CNT,
  output logic [ADDR_WIDTH-1:0] STK_DATA_IN,
  output logic                  STK_CE,
  output logic                  STK_nRW,
  input  logic [ADDR_WIDTH-1:0] STK_DATA_OUT,
  input  logic                  STK_FULL,
  input  logic                  STK_EMPTY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PUSH  = 3'd1;
  localparam logic [2:0] S_POP   = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic [ADDR_WIDTH-1:0] tgt_addr;
  logic [ADDR_WIDTH-1:0] pc_out_q;
  logic [DEPTH:0]        depth_q;
  logic                  ovf_q;
  logic                  unf_q;

  logic idle;
  logic take_flush;
  logic take_call;
  logic take_ret;
  logic ovf_set;
  logic unf_set;
  logic depth_zero;

  // Request arbitration: only one request wins per accept edge, the rest drop.
  always_comb begin
    idle       = (state == S_IDLE);
    take_flush = idle && FLUSH;
    take_call  = idle && !FLUSH && CALL;
    take_ret   = idle && !FLUSH && !CALL && RET;
    ovf_set    = take_call && STK_FULL;
    unf_set    = take_ret && STK_EMPTY;
    depth_zero = (depth_q == '0);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= S_IDLE;
      ret_addr <= '0;
      tgt_addr <= '0;
      pc_out_q <= '0;
      depth_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take_flush) begin
            state <= S_FLUSH;
          end else if (take_call) begin
            if (STK_FULL) begin
              state <= S_FAULT;
            end else begin
              // Return address wraps modulo 2**ADDR_WIDTH.
              ret_addr <= PC_IN + 1'b1;
              tgt_addr <= TARGET;
              state    <= S_PUSH;
            end
          end else if (take_ret) begin
            state <= STK_EMPTY ? S_FAULT : S_POP;
          end
        end
        S_PUSH: begin
          // Only reachable with the stack not full, so the count cannot
          // exceed 2**DEPTH.
          depth_q  <= depth_q + 1'b1;
          pc_out_q <= tgt_addr;
          state    <= S_LOAD;
        end
        S_POP: begin
          // Top-of-stack is still valid at the edge that performs the pop.
          depth_q  <= depth_q - 1'b1;
          pc_out_q <= STK_DATA_OUT;
          state    <= S_LOAD;
        end
        S_FLUSH: begin
          // depth_q mirrors the stack occupancy, so it stands in for
          // STK_EMPTY and keeps the strobe free of any input-to-output path.
          if (depth_zero) begin
            state <= S_IDLE;
          end else begin
            depth_q <= depth_q - 1'b1;
          end
        end
        S_LOAD:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a new error at the same edge as CLR_ERR leaves the flag set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set || (ovf_q && !CLR_ERR);
      unf_q <= unf_set || (unf_q && !CLR_ERR);
    end
  end

  always_comb begin
    PC_OUT      = pc_out_q;
    PC_LOAD     = (state == S_LOAD);
    BUSY        = !idle;
    DONE        = (state == S_LOAD) || (state == S_FAULT) ||
                  ((state == S_FLUSH) && depth_zero);
    ERR_OVF     = ovf_q;
    ERR_UNF     = unf_q;
    DEPTH_CNT   = depth_q;
    STK_CE      = (state == S_PUSH) || (state == S_POP) ||
                  ((state == S_FLUSH) && !depth_zero);
    STK_nRW     = (state == S_PUSH);
    STK_DATA_IN = (state == S_PUSH) ? ret_addr : '0;
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - self-checking bench for stack_ctrl with a behavioural 8x8 stack

module tb_stack_ctrl;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       CALL = 1'b0, RET = 1'b0, FLUSH = 1'b0, CLR_ERR = 1'b0;
  logic [7:0] PC_IN = 8'h00, TARGET = 8'h00;
  logic [7:0] PC_OUT, STK_DATA_IN, STK_DATA_OUT;
  logic       PC_LOAD, BUSY, DONE, ERR_OVF, ERR_UNF, STK_CE, STK_nRW, STK_FULL, STK_EMPTY;
  logic [3:0] DEPTH_CNT;

  always #5 CLK = ~CLK;

  stack_ctrl #(.ADDR_WIDTH(8), .DEPTH(3)) dut (
    .CLK(CLK), .nRST(nRST), .CALL(CALL), .RET(RET), .FLUSH(FLUSH), .CLR_ERR(CLR_ERR),
    .PC_IN(PC_IN), .TARGET(TARGET), .PC_OUT(PC_OUT), .PC_LOAD(PC_LOAD), .BUSY(BUSY),
    .DONE(DONE), .ERR_OVF(ERR_OVF), .ERR_UNF(ERR_UNF), .DEPTH_CNT(DEPTH_CNT),
    .STK_DATA_IN(STK_DATA_IN), .STK_CE(STK_CE), .STK_nRW(STK_nRW),
    .STK_DATA_OUT(STK_DATA_OUT), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY)
  );

  // Behavioural return-address stack sharing nRST with the controller.
  logic [7:0] mem [0:7];
  logic [3:0] sp;
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sp <= 4'd0;
    end else if (STK_CE) begin
      if (STK_nRW && sp < 4'd8) begin
        mem[sp[2:0]] <= STK_DATA_IN;
        sp <= sp + 4'd1;
      end else if (!STK_nRW && sp > 4'd0) begin
        sp <= sp - 4'd1;
      end
    end
  end
  assign STK_FULL     = (sp == 4'd8);
  assign STK_EMPTY    = (sp == 4'd0);
  wire [3:0] sp_m1    = sp - 4'd1;
  assign STK_DATA_OUT = (sp != 4'd0) ? mem[sp_m1[2:0]] : 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard of expected PC_OUT values plus a reference of pushed return addresses.
  logic [7:0] sb[$];
  logic [7:0] ref_q[$];

  int         cyc, pu, po;
  logic       ld;
  logic [7:0] pcs, pd;

  function automatic logic [7:0] sb_next();
    if (sb.size() != 0) return sb.pop_front();
    return 8'hxx;
  endfunction

  task automatic issue(input logic c, input logic r, input logic f, input logic clr,
                       input logic [7:0] pc, input logic [7:0] tg);
    logic [7:0] ra;
    int guard;
    guard = 0;
    @(negedge CLK);
    while (BUSY && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    ra = pc + 8'd1;
    if (f) begin
      ref_q.delete();
    end else if (c) begin
      if (ref_q.size() < 8) begin
        ref_q.push_back(ra);
        sb.push_back(tg);
      end
    end else if (r) begin
      if (ref_q.size() > 0) sb.push_back(ref_q.pop_back());
    end
    CALL = c; RET = r; FLUSH = f; CLR_ERR = clr; PC_IN = pc; TARGET = tg;
    @(posedge CLK);
    #1;
    CALL = 1'b0; RET = 1'b0; FLUSH = 1'b0; CLR_ERR = 1'b0;
  endtask

  // Watches cycles until DONE; cyc stays 0 if DONE never arrives.
  task automatic wait_done(output int c, output int npu, output int npo,
                           output logic l, output logic [7:0] p, output logic [7:0] d);
    c = 0; npu = 0; npo = 0; l = 1'b0; p = 8'h00; d = 8'h00;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (STK_CE && STK_nRW) begin npu++; d = STK_DATA_IN; end
      if (STK_CE && !STK_nRW) npo++;
      if (PC_LOAD) begin l = 1'b1; p = PC_OUT; end
      if (DONE) begin c = i; break; end
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({PC_OUT, PC_LOAD, BUSY, DONE, ERR_OVF, ERR_UNF, DEPTH_CNT, STK_DATA_IN, STK_CE, STK_nRW} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got pc=%h ld=%b busy=%b done=%b depth=%0d ce=%b required all zero",
               PC_OUT, PC_LOAD, BUSY, DONE, DEPTH_CNT, STK_CE);
    end
    nRST = 1'b1;
  endtask

  task automatic test_call_ret();
    logic [7:0] e;
    issue(1, 0, 0, 0, 8'h10, 8'h80);
    wait_done(cyc, pu, po, ld, pcs, pd);
    e = sb_next();
    n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL call_latency: got %0d required 2", cyc); end
    n_cmp++; if ({pu, pd} !== {32'd1, 8'h11}) begin n_bad++; $display("FAIL call_push: got n=%0d data=%h required n=1 data=11", pu, pd); end
    n_cmp++; if ({ld, pcs} !== {1'b1, e}) begin n_bad++; $display("FAIL call_pc: got ld=%b pc=%h required ld=1 pc=%h", ld, pcs, e); end
    n_cmp++; if (DEPTH_CNT !== 4'd1) begin n_bad++; $display("FAIL call_depth: got %0d required 1", DEPTH_CNT); end

    issue(0, 1, 0, 0, 8'h00, 8'h00);
    wait_done(cyc, pu, po, ld, pcs, pd);
    e = sb_next();
    n_cmp++; if ({cyc, po} !== {32'd2, 32'd1}) begin n_bad++; $display("FAIL ret_timing: got cyc=%0d pops=%0d required 2 and 1", cyc, po); end
    n_cmp++; if ({ld, pcs} !== {1'b1, e}) begin n_bad++; $display("FAIL ret_pc: got ld=%b pc=%h required ld=1 pc=%h", ld, pcs, e); end
    n_cmp++; if ({DEPTH_CNT, STK_EMPTY} !== {4'd0, 1'b1}) begin n_bad++; $display("FAIL ret_empty: got depth=%0d empty=%b required 0 and 1", DEPTH_CNT, STK_EMPTY); end
  endtask

  task automatic test_full();
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      issue(1, 0, 0, 0, 8'(i), 8'h40 + 8'(i));
      wait_done(cyc, pu, po, ld, pcs, pd);
      e = sb_next();
      n_cmp++; if ({ld, pcs, pu} !== {1'b1, e, 32'd1}) begin n_bad++; $display("FAIL fill_call%0d: got ld=%b pc=%h pushes=%0d required 1 %h 1", i, ld, pcs, pu, e); end
    end
    issue(1, 0, 0, 0, 8'h20, 8'h99);
    wait_done(cyc, pu, po, ld, pcs, pd);
    n_cmp++; if ({cyc, pu, ld} !== {32'd1, 32'd0, 1'b0}) begin n_bad++; $display("FAIL ovf_fault: got cyc=%0d pushes=%0d ld=%b required 1 0 0", cyc, pu, ld); end
    n_cmp++; if ({ERR_OVF, DEPTH_CNT} !== {1'b1, 4'd8}) begin n_bad++; $display("FAIL ovf_flag: got ovf=%b depth=%0d required 1 and 8", ERR_OVF, DEPTH_CNT); end
    for (int i = 0; i < 8; i++) begin
      issue(0, 1, 0, 0, 8'h00, 8'h00);
      wait_done(cyc, pu, po, ld, pcs, pd);
      e = sb_next();
      n_cmp++; if ({ld, pcs} !== {1'b1, e}) begin n_bad++; $display("FAIL drain_ret%0d: got ld=%b pc=%h required ld=1 pc=%h", i, ld, pcs, e); end
    end
    n_cmp++; if (DEPTH_CNT !== 4'd0) begin n_bad++; $display("FAIL drain_depth: got %0d required 0", DEPTH_CNT); end
  endtask

  task automatic test_underflow();
    issue(0, 1, 0, 0, 8'h00, 8'h00);
    wait_done(cyc, pu, po, ld, pcs, pd);
    n_cmp++; if ({cyc, pu, po, ld} !== {32'd1, 32'd0, 32'd0, 1'b0}) begin n_bad++; $display("FAIL unf_fault: got cyc=%0d pu=%0d po=%0d ld=%b required 1 0 0 0", cyc, pu, po, ld); end
    n_cmp++; if (ERR_UNF !== 1'b1) begin n_bad++; $display("FAIL unf_flag: got %b required 1", ERR_UNF); end
    issue(0, 1, 0, 1, 8'h00, 8'h00);
    wait_done(cyc, pu, po, ld, pcs, pd);
    n_cmp++; if (ERR_UNF !== 1'b1) begin n_bad++; $display("FAIL unf_clr_race: got %b required 1", ERR_UNF); end
    issue(0, 0, 0, 1, 8'h00, 8'h00);
    n_cmp++; if ({ERR_UNF, ERR_OVF} !== 2'b00) begin n_bad++; $display("FAIL clr_err: got unf=%b ovf=%b required 0 0", ERR_UNF, ERR_OVF); end
  endtask

  task automatic test_flush_priority();
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      issue(1, 0, 0, 0, 8'h50 + 8'(i), 8'h60);
      wait_done(cyc, pu, po, ld, pcs, pd);
      e = sb_next();
    end
    issue(0, 0, 1, 0, 8'h00, 8'h00);
    wait_done(cyc, pu, po, ld, pcs, pd);
    n_cmp++; if ({cyc, po, pu, ld} !== {32'd4, 32'd3, 32'd0, 1'b0}) begin n_bad++; $display("FAIL flush3: got cyc=%0d pops=%0d pushes=%0d ld=%b required 4 3 0 0", cyc, po, pu, ld); end
    n_cmp++; if ({DEPTH_CNT, STK_EMPTY, ERR_UNF} !== {4'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL flush_state: got depth=%0d empty=%b unf=%b required 0 1 0", DEPTH_CNT, STK_EMPTY, ERR_UNF); end

    issue(1, 1, 0, 0, 8'h30, 8'h90);
    wait_done(cyc, pu, po, ld, pcs, pd);
    e = sb_next();
    n_cmp++; if ({pu, po, ld, pcs, DEPTH_CNT} !== {32'd1, 32'd0, 1'b1, e, 4'd1}) begin n_bad++; $display("FAIL call_over_ret: got pu=%0d po=%0d ld=%b pc=%h depth=%0d required 1 0 1 %h 1", pu, po, ld, pcs, DEPTH_CNT, e); end

    issue(1, 0, 1, 0, 8'h31, 8'h91);
    wait_done(cyc, pu, po, ld, pcs, pd);
    n_cmp++; if ({cyc, pu, po, DEPTH_CNT} !== {32'd2, 32'd0, 32'd1, 4'd0}) begin n_bad++; $display("FAIL flush_over_call: got cyc=%0d pu=%0d po=%0d depth=%0d required 2 0 1 0", cyc, pu, po, DEPTH_CNT); end
  endtask

  task automatic test_wrap_reset();
    logic [7:0] e;
    issue(1, 0, 0, 0, 8'hFF, 8'h55);
    wait_done(cyc, pu, po, ld, pcs, pd);
    e = sb_next();
    n_cmp++; if ({pu, pd, pcs} !== {32'd1, 8'h00, e}) begin n_bad++; $display("FAIL wrap_push: got n=%0d data=%h pc=%h required 1 00 %h", pu, pd, pcs, e); end
    issue(0, 1, 0, 0, 8'h00, 8'h00);
    wait_done(cyc, pu, po, ld, pcs, pd);
    e = sb_next();
    n_cmp++; if ({ld, pcs} !== {1'b1, e}) begin n_bad++; $display("FAIL wrap_ret: got ld=%b pc=%h required 1 %h", ld, pcs, e); end

    issue(1, 0, 0, 0, 8'h22, 8'h66);
    n_cmp++; if ({STK_CE, STK_nRW, STK_DATA_IN} !== {1'b1, 1'b1, 8'h23}) begin n_bad++; $display("FAIL push_strobe: got ce=%b nrw=%b data=%h required 1 1 23", STK_CE, STK_nRW, STK_DATA_IN); end
    #2 nRST = 1'b0;
    sb.delete();
    ref_q.delete();
    #1;
    n_cmp++;
    if ({PC_OUT, PC_LOAD, BUSY, DONE, ERR_OVF, ERR_UNF, DEPTH_CNT, STK_DATA_IN, STK_CE, STK_nRW} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_push: got pc=%h busy=%b depth=%0d ce=%b data=%h required all zero", PC_OUT, BUSY, DEPTH_CNT, STK_CE, STK_DATA_IN);
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    n_cmp++; if ({DEPTH_CNT, STK_EMPTY, BUSY} !== {4'd0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL after_reset: got depth=%0d empty=%b busy=%b required 0 1 0", DEPTH_CNT, STK_EMPTY, BUSY); end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] e;
    issue(1, 0, 0, 0, 8'h05, 8'h70);
    RET = 1'b1; FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    RET = 1'b0; FLUSH = 1'b0;
    wait_done(cyc, pu, po, ld, pcs, pd);
    e = sb_next();
    n_cmp++; if ({cyc, ld, pcs} !== {32'd1, 1'b1, e}) begin n_bad++; $display("FAIL busy_call: got cyc=%0d ld=%b pc=%h required 1 1 %h", cyc, ld, pcs, e); end
    repeat (3) @(negedge CLK);
    n_cmp++; if ({BUSY, DEPTH_CNT, STK_EMPTY} !== {1'b0, 4'd1, 1'b0}) begin n_bad++; $display("FAIL busy_ignored: got busy=%b depth=%0d empty=%b required 0 1 0", BUSY, DEPTH_CNT, STK_EMPTY); end
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_full();
    test_underflow();
    test_flush_priority();
    test_wrap_reset();
    test_busy_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
